// File: rtl/rv_decode_queue.sv
// rv_decode_queue
// ---------------------------------------------------------------------------
// RV32I decode stage with a small instruction queue. Fetch pushes raw
// instruction words and PCs into a DEPTH-entry FIFO over a valid/ready
// handshake. The decoded fields go into a registered output stage. Execute
// drains that stage over a second valid/ready handshake. An empty queue lets
// an incoming word go straight into the output register, so the minimum
// latency is one cycle. Unrecognised encodings are flagged as illegal and
// still pass through the handshake like any other instruction.
//
// Optional feature macro: DECODE_RV32M_EN
//   defined   -> R-type funct7=0000001 decodes as MUL..REMU (op 37..44)
//   undefined -> those encodings are illegal (op = 2^OPW-1)
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   flush               synchronous discard of FIFO and output register
//   in_valid/in_ready   fetch handshake; in_instr/in_pc are the payload
//   out_valid/out_ready execute handshake
//   out_pc, opcode, funct3, funct7, rs1, rs2, rd, imm, op, illegal
//                       registered decoded fields
//   count               FIFO occupancy, output register not included
module rv_decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int OPW   = 6
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_instr,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [6:0]               opcode,
    output logic [2:0]               funct3,
    output logic [6:0]               funct7,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [4:0]               rd,
    output logic [XLEN-1:0]          imm,
    output logic [OPW-1:0]           op,
    output logic                     illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [4:0] OPC_R      = 5'b01100;
    localparam logic [4:0] OPC_I      = 5'b00100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;

    logic            push, load, pop, bypass, fifo_push, src_valid;
    logic [XLEN-1:0] src_instr, src_pc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic            legal;
    logic [OPW-1:0]  op_idx;
    fmt_e            fmt;

    logic [2:0]      d_funct3;
    logic [6:0]      d_funct7;
    logic [4:0]      d_rs1, d_rs2, d_rd;
    logic [XLEN-1:0] d_imm;
    logic [OPW-1:0]  d_op;

    // in_ready ignores out_ready: a full queue stalls fetch even when execute
    // is draining in the same cycle.
    assign in_ready  = (count < DEPTH_C) && !flush;
    assign push      = in_valid && in_ready;
    assign load      = !out_valid || out_ready;
    assign pop       = load && (count != '0);
    // Only an empty FIFO lets the incoming word skip straight to the output.
    assign bypass    = load && (count == '0) && push;
    assign fifo_push = push && !bypass;
    assign src_valid = pop || bypass;
    assign src_instr = pop ? instr_mem[rd_ptr] : in_instr;
    assign src_pc    = pop ? pc_mem[rd_ptr]    : in_pc;

    assign f3 = src_instr[14:12];
    assign f7 = src_instr[31:25];

    assign imm_i = {{(XLEN-12){src_instr[31]}}, src_instr[31:20]};
    assign imm_s = {{(XLEN-12){src_instr[31]}}, src_instr[31:25], src_instr[11:7]};
    assign imm_b = {{(XLEN-13){src_instr[31]}}, src_instr[31], src_instr[7],
                    src_instr[30:25], src_instr[11:8], 1'b0};
    assign imm_u = {src_instr[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){src_instr[31]}}, src_instr[31], src_instr[19:12],
                    src_instr[20], src_instr[30:21], 1'b0};

    // Classify the selected word: legality, instruction format and op index.
    always_comb begin
        legal  = 1'b0;
        op_idx = '0;
        fmt    = FMT_I;
        if (src_instr[1:0] == 2'b11) begin
            case (src_instr[6:2])
                OPC_R: begin
                    fmt = FMT_R;
                    if (f7 == 7'h00) begin
                        legal = 1'b1;
                        case (f3)
                            3'd0:    op_idx = OPW'(0);
                            3'd1:    op_idx = OPW'(5);
                            3'd2:    op_idx = OPW'(8);
                            3'd3:    op_idx = OPW'(9);
                            3'd4:    op_idx = OPW'(2);
                            3'd5:    op_idx = OPW'(6);
                            3'd6:    op_idx = OPW'(3);
                            default: op_idx = OPW'(4);
                        endcase
                    end else if (f7 == 7'h20) begin
                        if (f3 == 3'd0) begin
                            legal  = 1'b1;
                            op_idx = OPW'(1);
                        end else if (f3 == 3'd5) begin
                            legal  = 1'b1;
                            op_idx = OPW'(7);
                        end
                    end
`ifdef DECODE_RV32M_EN
                    else if (f7 == 7'h01) begin
                        legal  = 1'b1;
                        op_idx = OPW'(37) + OPW'(f3);
                    end
`endif
                end
                OPC_I: begin
                    fmt = FMT_I;
                    case (f3)
                        3'd0:    begin legal = 1'b1; op_idx = OPW'(10); end
                        3'd1:    begin legal = (f7 == 7'h00); op_idx = OPW'(14); end
                        3'd2:    begin legal = 1'b1; op_idx = OPW'(17); end
                        3'd3:    begin legal = 1'b1; op_idx = OPW'(18); end
                        3'd4:    begin legal = 1'b1; op_idx = OPW'(11); end
                        3'd5: begin
                            // imm[11:5] picks logical vs arithmetic right shift.
                            legal  = (f7 == 7'h00) || (f7 == 7'h20);
                            op_idx = (f7 == 7'h20) ? OPW'(16) : OPW'(15);
                        end
                        3'd6:    begin legal = 1'b1; op_idx = OPW'(12); end
                        default: begin legal = 1'b1; op_idx = OPW'(13); end
                    endcase
                end
                OPC_LOAD: begin
                    fmt = FMT_I;
                    case (f3)
                        3'd0:    begin legal = 1'b1; op_idx = OPW'(19); end
                        3'd1:    begin legal = 1'b1; op_idx = OPW'(20); end
                        3'd2:    begin legal = 1'b1; op_idx = OPW'(21); end
                        3'd4:    begin legal = 1'b1; op_idx = OPW'(22); end
                        3'd5:    begin legal = 1'b1; op_idx = OPW'(23); end
                        default: legal = 1'b0;
                    endcase
                end
                OPC_STORE: begin
                    fmt = FMT_S;
                    case (f3)
                        3'd0:    begin legal = 1'b1; op_idx = OPW'(24); end
                        3'd1:    begin legal = 1'b1; op_idx = OPW'(25); end
                        3'd2:    begin legal = 1'b1; op_idx = OPW'(26); end
                        default: legal = 1'b0;
                    endcase
                end
                OPC_LUI:   begin fmt = FMT_U; legal = 1'b1; op_idx = OPW'(27); end
                OPC_AUIPC: begin fmt = FMT_U; legal = 1'b1; op_idx = OPW'(28); end
                OPC_BRANCH: begin
                    fmt = FMT_B;
                    case (f3)
                        3'd0:    begin legal = 1'b1; op_idx = OPW'(29); end
                        3'd1:    begin legal = 1'b1; op_idx = OPW'(30); end
                        3'd4:    begin legal = 1'b1; op_idx = OPW'(31); end
                        3'd5:    begin legal = 1'b1; op_idx = OPW'(32); end
                        3'd6:    begin legal = 1'b1; op_idx = OPW'(33); end
                        3'd7:    begin legal = 1'b1; op_idx = OPW'(34); end
                        default: legal = 1'b0;
                    endcase
                end
                OPC_JAL:  begin fmt = FMT_J; legal = 1'b1; op_idx = OPW'(35); end
                OPC_JALR: begin fmt = FMT_I; legal = (f3 == 3'd0); op_idx = OPW'(36); end
                default:  legal = 1'b0;
            endcase
        end
    end

    // Populate only the fields the format defines. Illegal words keep just
    // opcode and funct3 so execute can report what it saw.
    always_comb begin
        d_funct3 = f3;
        d_funct7 = '0;
        d_rs1    = '0;
        d_rs2    = '0;
        d_rd     = '0;
        d_imm    = '0;
        d_op     = legal ? op_idx : '1;
        if (legal) begin
            case (fmt)
                FMT_R: begin
                    d_funct7 = f7;
                    d_rs1    = src_instr[19:15];
                    d_rs2    = src_instr[24:20];
                    d_rd     = src_instr[11:7];
                end
                FMT_I: begin
                    d_rs1 = src_instr[19:15];
                    d_rd  = src_instr[11:7];
                    d_imm = imm_i;
                end
                FMT_S: begin
                    d_rs1 = src_instr[19:15];
                    d_rs2 = src_instr[24:20];
                    d_imm = imm_s;
                end
                FMT_B: begin
                    d_rs1 = src_instr[19:15];
                    d_rs2 = src_instr[24:20];
                    d_imm = imm_b;
                end
                FMT_U: begin
                    d_funct3 = '0;
                    d_rd     = src_instr[11:7];
                    d_imm    = imm_u;
                end
                default: begin
                    d_funct3 = '0;
                    d_rd     = src_instr[11:7];
                    d_imm    = imm_j;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)       rd_ptr <= rd_ptr + AW'(1);
            case ({fifo_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            opcode    <= '0;
            funct3    <= '0;
            funct7    <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            imm       <= '0;
            op        <= '0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= src_valid;
            if (src_valid) begin
                out_pc  <= src_pc;
                opcode  <= src_instr[6:0];
                funct3  <= d_funct3;
                funct7  <= d_funct7;
                rs1     <= d_rs1;
                rs2     <= d_rs2;
                rd      <= d_rd;
                imm     <= d_imm;
                op      <= d_op;
                illegal <= !legal;
            end
        end
    end

endmodule

// File: tb/tb_rv_decode_queue.sv
// tb_rv_decode_queue
// ---------------------------------------------------------------------------
// Self-checking bench for rv_decode_queue. A table-driven ISA model decodes
// words from the mnemonic list, and a queue of in-flight instructions tracks
// what the output register and FIFO must hold. Honours DECODE_RV32M_EN.
module tb_rv_decode_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [5:0]  op;
    logic        illegal;
    logic [2:0]  count;

    rv_decode_queue #(.XLEN(32), .DEPTH(DEPTH), .OPW(6)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .op(op),
        .illegal(illegal), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [5:0]  op;
        logic        ill;
        logic [31:0] pc;
    } dec_t;

    typedef struct {
        logic [4:0] opc;
        int         f3;
        int         f7;
        int         op;
        byte        fmt;
    } ent_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;

    ent_t  tbl[$];
    item_t items[$];
    int    vectors = 0;
    int    miscompares = 0;

    function automatic void add(logic [4:0] opc, int f3, int f7, int opn, byte fmt);
        ent_t e;
        e.opc = opc; e.f3 = f3; e.f7 = f7; e.op = opn; e.fmt = fmt;
        tbl.push_back(e);
    endfunction

    // Mnemonic list: opcode[6:2], funct3 (-1 any), funct7/imm[11:5] (-1 any).
    task automatic init_table();
        add(5'b01100, 0, 0, 0, "R");  add(5'b01100, 0, 32, 1, "R");
        add(5'b01100, 4, 0, 2, "R");  add(5'b01100, 6, 0, 3, "R");
        add(5'b01100, 7, 0, 4, "R");  add(5'b01100, 1, 0, 5, "R");
        add(5'b01100, 5, 0, 6, "R");  add(5'b01100, 5, 32, 7, "R");
        add(5'b01100, 2, 0, 8, "R");  add(5'b01100, 3, 0, 9, "R");
`ifdef DECODE_RV32M_EN
        for (int k = 0; k < 8; k++) add(5'b01100, k, 1, 37 + k, "R");
`endif
        add(5'b00100, 0, -1, 10, "I"); add(5'b00100, 4, -1, 11, "I");
        add(5'b00100, 6, -1, 12, "I"); add(5'b00100, 7, -1, 13, "I");
        add(5'b00100, 1, 0, 14, "I");  add(5'b00100, 5, 0, 15, "I");
        add(5'b00100, 5, 32, 16, "I"); add(5'b00100, 2, -1, 17, "I");
        add(5'b00100, 3, -1, 18, "I");
        add(5'b00000, 0, -1, 19, "I"); add(5'b00000, 1, -1, 20, "I");
        add(5'b00000, 2, -1, 21, "I"); add(5'b00000, 4, -1, 22, "I");
        add(5'b00000, 5, -1, 23, "I");
        add(5'b01000, 0, -1, 24, "S"); add(5'b01000, 1, -1, 25, "S");
        add(5'b01000, 2, -1, 26, "S");
        add(5'b01101, -1, -1, 27, "U"); add(5'b00101, -1, -1, 28, "U");
        add(5'b11000, 0, -1, 29, "B"); add(5'b11000, 1, -1, 30, "B");
        add(5'b11000, 4, -1, 31, "B"); add(5'b11000, 5, -1, 32, "B");
        add(5'b11000, 6, -1, 33, "B"); add(5'b11000, 7, -1, 34, "B");
        add(5'b11011, -1, -1, 35, "J"); add(5'b11001, 0, -1, 36, "I");
    endtask

    function automatic dec_t model_decode(logic [31:0] w, logic [31:0] pc);
        dec_t d;
        int   hit;
        int   v;
        d = '0;
        d.opcode = w[6:0];
        d.f3 = w[14:12];
        d.pc = pc;
        d.op = 6'd63;
        d.ill = 1'b1;
        hit = -1;
        if (w[1:0] == 2'b11) begin
            foreach (tbl[i]) begin
                if (tbl[i].opc == w[6:2] &&
                    (tbl[i].f3 < 0 || tbl[i].f3 == int'(w[14:12])) &&
                    (tbl[i].f7 < 0 || tbl[i].f7 == int'(w[31:25])))
                    hit = i;
            end
        end
        if (hit >= 0) begin
            d.ill = 1'b0;
            d.op = 6'(tbl[hit].op);
            v = 0;
            case (tbl[hit].fmt)
                "R": begin d.f7 = w[31:25]; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7]; end
                "I": begin
                    d.rs1 = w[19:15]; d.rd = w[11:7];
                    v = int'(w[30:20]); if (w[31]) v -= 2048;
                    d.imm = 32'(v);
                end
                "S": begin
                    d.rs1 = w[19:15]; d.rs2 = w[24:20];
                    v = int'(w[30:25]) * 32 + int'(w[11:7]); if (w[31]) v -= 2048;
                    d.imm = 32'(v);
                end
                "B": begin
                    d.rs1 = w[19:15]; d.rs2 = w[24:20];
                    v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
                    if (w[31]) v -= 4096;
                    d.imm = 32'(v);
                end
                "U": begin d.f3 = 3'd0; d.rd = w[11:7]; d.imm = w & 32'hFFFF_F000; end
                default: begin
                    d.f3 = 3'd0; d.rd = w[11:7];
                    v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
                    if (w[31]) v -= (1 << 20);
                    d.imm = 32'(v);
                end
            endcase
        end
        return d;
    endfunction

    function automatic dec_t observed();
        dec_t d;
        d.opcode = opcode; d.f3 = funct3; d.f7 = funct7;
        d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.imm = imm;
        d.op = op; d.ill = illegal; d.pc = out_pc;
        return d;
    endfunction

    function automatic int exp_count();
        return (items.size() > 0) ? items.size() - 1 : 0;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        ent_t        e;
        int          sel;
        sel = $urandom_range(0, 19);
        w = $urandom;
        if (sel == 0) return w;
        if (sel == 1) begin
            w[6:0] = 7'h33; w[31:25] = 7'h01;
            return w;
        end
        e = tbl[$urandom_range(0, tbl.size() - 1)];
        w[6:0] = {e.opc, 2'b11};
        if (e.f3 >= 0) w[14:12] = 3'(e.f3);
        if (e.f7 >= 0) w[31:25] = 7'(e.f7);
        return w;
    endfunction

    // One clock: drive inputs, sample in_ready, advance the reference queue.
    task automatic step(input logic v, input logic [31:0] w, input logic [31:0] p,
                        input logic ordy, input logic fl,
                        output logic got_ready, output logic exp_ready);
        logic acc, cons;
        in_valid = v; in_instr = w; in_pc = p; out_ready = ordy; flush = fl;
        #1;
        got_ready = in_ready;
        exp_ready = (exp_count() < DEPTH) && !fl;
        acc = v && exp_ready;
        cons = (items.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (fl) items.delete();
        else begin
            if (cons) void'(items.pop_front());
            if (acc) items.push_back('{w, p});
        end
    endtask

    task automatic drain();
        logic gr, er;
        step(1'b0, '0, '0, 1'b0, 1'b1, gr, er);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_instr = 32'h003100B3; in_pc = 32'h40; out_ready = 1'b1;
        #22;
        vectors++;
        if (out_valid !== 1'b0 || count !== 3'd0)
            begin miscompares++; $display("[TB] FAIL reset_state: out_valid=%b count=%0d, want 0/0", out_valid, count); end
        vectors++;
        if (observed() !== dec_t'(0))
            begin miscompares++; $display("[TB] FAIL reset_fields: got %h want 0", observed()); end
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1)
            begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single_add();
        logic gr, er;
        step(1'b1, 32'h003100B3, 32'h100, 1'b1, 1'b0, gr, er);
        vectors++;
        if (out_valid !== 1'b1 || op !== 6'd0 || rd !== 5'd1 || rs1 !== 5'd2 || rs2 !== 5'd3 ||
            imm !== 32'd0 || illegal !== 1'b0 || out_pc !== 32'h100)
            begin miscompares++; $display("[TB] FAIL add_decode: got v=%b op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h ill=%b pc=%h, want 1/0/1/2/3/0/0/100",
                                          out_valid, op, rd, rs1, rs2, imm, illegal, out_pc); end
        step(1'b0, '0, '0, 1'b1, 1'b0, gr, er);
        vectors++;
        if (out_valid !== 1'b0)
            begin miscompares++; $display("[TB] FAIL add_drain: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_fill_drain();
        logic [31:0] w [6] = '{32'h003100B3, 32'h40208133, 32'h00500093,
                               32'h0000A103, 32'h00112023, 32'h123452B7};
        logic [31:0] got_pcs[$];
        logic        gr, er;
        int          idx;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, w[i], 32'h200 + 32'(4 * i), 1'b0, 1'b0, gr, er);
            vectors++;
            if (gr !== 1'b1)
                begin miscompares++; $display("[TB] FAIL fill_ready %0d: in_ready=%b want 1", i, gr); end
        end
        vectors++;
        if (count !== 3'd4 || out_valid !== 1'b1)
            begin miscompares++; $display("[TB] FAIL fill_full: count=%0d out_valid=%b want 4/1", count, out_valid); end
        step(1'b1, w[5], 32'h214, 1'b0, 1'b0, gr, er);
        vectors++;
        if (gr !== 1'b0)
            begin miscompares++; $display("[TB] FAIL full_stall: in_ready=%b want 0", gr); end
        idx = 5;
        for (int c = 0; c < 20 && got_pcs.size() < 6; c++) begin
            if (out_valid === 1'b1) got_pcs.push_back(out_pc);
            step(idx < 6, w[(idx < 6) ? idx : 0], 32'h200 + 32'(4 * idx), 1'b1, 1'b0, gr, er);
            if (c == 0) begin
                vectors++;
                if (gr !== 1'b0)
                    begin miscompares++; $display("[TB] FAIL full_pop_stall: in_ready=%b want 0", gr); end
            end
            if (idx < 6 && er) idx++;
        end
        vectors++;
        if (got_pcs.size() != 6)
            begin miscompares++; $display("[TB] FAIL drain_len: got %0d instructions want 6", got_pcs.size()); end
        foreach (got_pcs[i]) begin
            vectors++;
            if (got_pcs[i] !== 32'h200 + 32'(4 * i))
                begin miscompares++; $display("[TB] FAIL drain_order %0d: pc=%h want %h", i, got_pcs[i], 32'h200 + 32'(4 * i)); end
        end
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0)
            begin miscompares++; $display("[TB] FAIL drain_empty: count=%0d out_valid=%b want 0/0", count, out_valid); end
    endtask

    task automatic test_branch_jal();
        logic gr, er;
        step(1'b1, 32'hFE000EE3, 32'h300, 1'b1, 1'b0, gr, er);
        vectors++;
        if (op !== 6'd29 || imm !== 32'hFFFF_FFFC || illegal !== 1'b0)
            begin miscompares++; $display("[TB] FAIL beq: op=%0d imm=%h ill=%b want 29/fffffffc/0", op, imm, illegal); end
        step(1'b1, 32'h0000006F, 32'h304, 1'b1, 1'b0, gr, er);
        vectors++;
        if (op !== 6'd35 || imm !== 32'd0 || rd !== 5'd0 || funct3 !== 3'd0)
            begin miscompares++; $display("[TB] FAIL jal: op=%0d imm=%h rd=%0d f3=%0d want 35/0/0/0", op, imm, rd, funct3); end
        drain();
    endtask

    task automatic test_illegal();
        logic gr, er;
        step(1'b1, 32'h0000007F, 32'h400, 1'b1, 1'b0, gr, er);
        vectors++;
        if (out_valid !== 1'b1 || illegal !== 1'b1 || op !== 6'd63 || rd !== 5'd0 || opcode !== 7'h7F)
            begin miscompares++; $display("[TB] FAIL illegal_opcode: v=%b ill=%b op=%0d rd=%0d opc=%h want 1/1/63/0/7f",
                                          out_valid, illegal, op, rd, opcode); end
        step(1'b1, 32'h20208133, 32'h404, 1'b1, 1'b0, gr, er);
        vectors++;
        if (out_valid !== 1'b1 || illegal !== 1'b1 || op !== 6'd63 || rd !== 5'd0 ||
            rs1 !== 5'd0 || imm !== 32'd0 || out_pc !== 32'h404)
            begin miscompares++; $display("[TB] FAIL illegal_funct7: v=%b ill=%b op=%0d rd=%0d rs1=%0d imm=%h pc=%h",
                                          out_valid, illegal, op, rd, rs1, imm, out_pc); end
        drain();
    endtask

    task automatic test_flush();
        logic gr, er;
        for (int i = 0; i < 4; i++) step(1'b1, 32'h00500093, 32'h500 + 32'(4 * i), 1'b0, 1'b0, gr, er);
        vectors++;
        if (count !== 3'd3 || out_valid !== 1'b1)
            begin miscompares++; $display("[TB] FAIL flush_setup: count=%0d out_valid=%b want 3/1", count, out_valid); end
        step(1'b1, 32'h003100B3, 32'h510, 1'b0, 1'b1, gr, er);
        vectors++;
        if (gr !== 1'b0)
            begin miscompares++; $display("[TB] FAIL flush_in_ready: in_ready=%b want 0", gr); end
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0)
            begin miscompares++; $display("[TB] FAIL flush_clear: count=%0d out_valid=%b want 0/0", count, out_valid); end
        step(1'b0, '0, '0, 1'b1, 1'b0, gr, er);
        vectors++;
        if (out_valid !== 1'b0 || count !== 3'd0)
            begin miscompares++; $display("[TB] FAIL flush_dropped_input: out_valid=%b count=%0d want 0/0", out_valid, count); end
    endtask

    task automatic test_mul();
        logic gr, er;
        logic [5:0] want_op;
        logic       want_ill;
`ifdef DECODE_RV32M_EN
        want_op = 6'd37; want_ill = 1'b0;
`else
        want_op = 6'd63; want_ill = 1'b1;
`endif
        step(1'b1, 32'h02208033, 32'h600, 1'b1, 1'b0, gr, er);
        vectors++;
        if (op !== want_op || illegal !== want_ill || out_valid !== 1'b1)
            begin miscompares++; $display("[TB] FAIL mul: op=%0d ill=%b v=%b want %0d/%b/1", op, illegal, out_valid, want_op, want_ill); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic gr, er;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'h00A00093, 32'h700 + 32'(4 * i), 1'b1, 1'b0, gr, er);
            vectors++;
            if (gr !== 1'b1 || out_valid !== 1'b1 || count !== 3'd0 || out_pc !== 32'h700 + 32'(4 * i))
                begin miscompares++; $display("[TB] FAIL back_to_back %0d: rdy=%b v=%b count=%0d pc=%h want 1/1/0/%h",
                                              i, gr, out_valid, count, out_pc, 32'h700 + 32'(4 * i)); end
        end
        drain();
    endtask

    task automatic test_random_stream();
        logic        v, o, f, gr, er;
        logic [31:0] w, pc;
        dec_t        got, want;
        pc = 32'h1000;
        for (int c = 0; c < 400; c++) begin
            v = ($urandom_range(0, 3) != 0);
            o = ($urandom_range(0, 9) < 6);
            f = ($urandom_range(0, 39) == 0);
            w = rand_word();
            step(v, w, pc, o, f, gr, er);
            if (v && er) pc += 32'd4;
            vectors++;
            if (gr !== er)
                begin miscompares++; $display("[TB] FAIL rand_in_ready cycle %0d: got %b want %b", c, gr, er); end
            vectors++;
            if (out_valid !== (items.size() > 0) || count !== 3'(exp_count()))
                begin miscompares++; $display("[TB] FAIL rand_occupancy cycle %0d: v=%b count=%0d want %0d/%0d",
                                              c, out_valid, count, items.size() > 0, exp_count()); end
            if (items.size() > 0) begin
                got = observed();
                want = model_decode(items[0].instr, items[0].pc);
                vectors++;
                if (got !== want)
                    begin miscompares++; $display("[TB] FAIL rand_fields cycle %0d instr %h: got %h want %h",
                                                  c, items[0].instr, got, want); end
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic gr, er;
        for (int i = 0; i < 3; i++) step(1'b1, 32'h003100B3, 32'h800 + 32'(4 * i), 1'b0, 1'b0, gr, er);
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || count !== 3'd0 || observed() !== dec_t'(0))
            begin miscompares++; $display("[TB] FAIL reset_mid: v=%b count=%0d fields=%h want all 0", out_valid, count, observed()); end
        items.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin miscompares++; $display("[TB] FAIL reset_mid_release: rdy=%b v=%b want 1/0", in_ready, out_valid); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        init_table();
        test_reset();
        test_single_add();
        test_fill_drain();
        test_branch_jal();
        test_illegal();
        test_flush();
        test_mul();
        test_back_to_back();
        test_random_stream();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rv_decode_queue.md
Name: rv_decode_queue

Overview:
- Parametrised RV32I decode stage with a small instruction queue.
- Accepts raw instruction words and PCs from fetch over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Presents registered decoded fields (opcode, funct3, funct7, rs1, rs2, rd, sign-extended imm, op index) to execute over a second valid/ready handshake.
- Adds illegal-instruction detection and pipeline flush.

Parameters:
- XLEN, 32, instruction/immediate/PC width; only 32 is supported.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- OPW, 6, width of the op index output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards the FIFO and the output register.
- in_valid  in  1  fetch presents in_instr/in_pc.
- in_ready  out  1  queue can accept this cycle.
- in_instr  in  XLEN  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  decoded instruction held in the output register.
- out_ready  in  1  execute consumes this cycle.
- out_pc  out  XLEN  PC of the decoded instruction.
- opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12]; 0 for U/J types.
- funct7  out  7  instr[31:25] for R type; 0 otherwise.
- rs1, rs2, rd  out  5 each  register indices; 0 where the format has no such field.
- imm  out  XLEN  sign-extended immediate per format (I, S, B, U, J); 0 for R type.
- op  out  OPW  op index.
- illegal  out  1  instruction not recognised.
- count  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the output register.

Behaviour:
- Reset: asynchronous on reset_n low.
  - FIFO pointers and count go to 0.
  - out_valid=0, illegal=0; all decoded outputs and out_pc = 0.
  - in_ready=1 from the first cycle after reset release.
- Input handshake:
  - in_ready = (count<DEPTH) && !flush. It does not depend on out_ready, so a full queue with a simultaneous pop still stalls input that cycle.
  - Accept when in_valid && in_ready.
- Output handshake: out_valid stays high and all outputs stay stable until out_ready. A transfer occurs when out_valid && out_ready.
- Output register load. The register loads when it is empty or being consumed this cycle:
  - If count>0: load from the FIFO head and pop it. The new input goes to the FIFO tail.
  - If count==0 and an input is accepted: load directly from the input (bypass). Minimum latency is 1 cycle, accept at t gives out_valid at t+1.
  - Otherwise: out_valid goes to 0.
- Order: strict FIFO order; no reordering or dropping except on flush.
- Throughput: one instruction per cycle sustained when out_ready=1.
- count tracking: push without pop gives +1, pop without push gives -1, push with pop leaves count unchanged. Pointers wrap modulo DEPTH.
- Flush: takes priority over all other events in its cycle.
  - Next cycle: count=0, out_valid=0.
  - An input presented during flush is not accepted (in_ready=0).
  - An output transfer in the flush cycle still counts as consumed by execute.
- Decode: combinational on the selected source word, registered into the outputs.
  - Format by opcode[6:2]: 01100 R, 00100 I-ALU, 00000 load, 01000 store, 01101 LUI, 00101 AUIPC, 11000 branch, 11011 JAL, 11001 JALR.
  - opcode[1:0] must be 11.
- op index:
  - R type: ADD0 SUB1 XOR2 OR3 AND4 SLL5 SRL6 SRA7 SLT8 SLTU9.
  - I-ALU: ADDI10 XORI11 ORI12 ANDI13 SLLI14 SRLI15 SRAI16 SLTI17 SLTIU18.
  - Loads: LB19 LH20 LW21 LBU22 LHU23.
  - Stores: SB24 SH25 SW26.
  - Upper immediates: LUI27 AUIPC28.
  - Branches: BEQ29 BNE30 BLT31 BGE32 BLTU33 BGEU34.
  - Jumps: JAL35 JALR36.
- Immediate widths:
  - B: 13-bit sign-extended, bit 0 = 0.
  - J: 21-bit sign-extended, bit 0 = 0.
  - U: instr[31:12] followed by 12 zero bits.
  - Shift-immediate ops: funct7 field = 0; imm[11:5] qualifies SRLI vs SRAI.
- Illegal instruction: unknown opcode, opcode[1:0]≠11, unlisted funct3/funct7 combination, or JALR with funct3≠0.
  - Sets illegal=1 and op=2^OPW-1 (63).
  - rs1, rs2, rd, imm = 0; opcode, funct3 and out_pc carry the raw values.
  - The instruction still flows through the handshake normally.
- Reset asserted mid-operation: all state clears immediately; queued instructions are lost.

Optional Feature:
- Macro: DECODE_RV32M_EN.
- Defined: R type with funct7=0000001 decodes as MUL37 MULH38 MULHSU39 MULHU40 DIV41 DIVU42 REM43 REMU44 (funct3 0..7), with illegal=0.
- Undefined: those encodings decode as illegal (op=63).

Test Plan:
- Reset then a single ADD (0x003100B3) with out_ready=1 → out_valid at +1 cycle, op=0, rd=1, rs1=2, rs2=3, imm=0, illegal=0.
- Stream of 6 instructions with out_ready=0, DEPTH=4 → 1 in the output register, 4 in the FIFO, in_ready=0 with count=4. Then out_ready=1 → all 6 emerge in order, count returns to 0.
- BEQ with negative offset (0xFE000EE3) → op=29, imm=0xFFFFFFFC. JAL 0x0000006F → op=35, imm=0.
- Word 0x0000007F, then SUB with funct7=0x10 → both give illegal=1, op=63, rd=0, still handshaked.
- Queue at count=3 plus a full output register, flush with in_valid=1 → next cycle count=0, out_valid=0, the input is not accepted.
- MUL 0x02208033 → op=37 with DECODE_RV32M_EN defined; illegal=1, op=63 without it.
